bin2bcd_seq: RTL

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Processes one input bit per clock, so area is constant in BIN_W instead of unrolled.
- Adds a start/busy/done handshake, an overflow flag and leading-zero blanking flags.
- Feeds the multi-digit 7-segment display driver, which consumes bcd plus blank per digit.

---
 rtl/bin2bcd_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with start/busy/done handshake, sticky overflow and leading-zero blanking flags.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                overflow,
    output logic [DIGITS-1:0]   blank
);
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t              r_state, w_next;
    logic [BIN_W-1:0]    r_sr;
    logic [4*DIGITS-1:0] r_acc, w_adj, w_acc_nx, r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_ovf, r_overflow, w_carry, w_last, w_load;
    logic [DIGITS-1:0]   r_blank;

    // bit d set when digit d and every digit above it are zero; ones digit never blanked
    function automatic logic [DIGITS-1:0] f_blank(input logic [4*DIGITS-1:0] a);
        logic z;
        f_blank = '0;
        z = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            z = z & (a[4*d+:4] == 4'd0);
            f_blank[d] = z;
        end
    endfunction

    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < DIGITS; d++)
            w_adj[4*d+:4] = (r_acc[4*d+:4] >= 4'd5) ? r_acc[4*d+:4] + 4'd3 : r_acc[4*d+:4];
    end

    // a 1 falling off the top digit is a carry worth 10^DIGITS
    assign w_acc_nx = {w_adj[4*DIGITS-2:0], r_sr[BIN_W-1]};
    assign w_carry  = w_adj[4*DIGITS-1];
    assign w_last   = r_cnt == CW'(BIN_W - 1);
    assign w_load   = start && r_state != SHIFT;

    always_comb begin
        w_next = r_state;
        if (r_state == SHIFT)
            w_next = w_last ? FINISH : SHIFT;
        else
            w_next = start ? SHIFT : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_blank    <= f_blank('0);
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_sr  <= bin;
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_sr  <= r_sr << 1;
                r_acc <= w_acc_nx;
                r_ovf <= r_ovf | w_carry;
                r_cnt <= r_cnt + CW'(1);
                // results land on the edge entering FINISH so they are valid alongside done
                if (w_last) begin
                    r_bcd      <= w_acc_nx;
                    r_overflow <= r_ovf | w_carry;
                    r_blank    <= f_blank(w_acc_nx);
                end
            end
        end
    end

    assign busy     = r_state == SHIFT;
    assign done     = r_state == FINISH;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;
    assign blank    = r_blank;
endmodule
